// File: rtl/mem_arb_pkg.sv
// Shared types for the memory-port arbiter: FSM states, port owner and
// the legal range of the memory read latency.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam int unsigned READ_LAT_MIN = 1;
  localparam int unsigned READ_LAT_MAX = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and load/store,
// one access at a time, data-priority with a bounded anti-starvation streak.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_valid_o,
  output logic [31:0]       d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_w_en_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              busy_o
);

  localparam int STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int WCNT_W   = 2;

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("mem_port_arbiter: READ_LAT out of range");
  end

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic                flushed_q, flushed_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic                mem_w_en_q, mem_w_en_d;
  logic [31:0]         if_rdata_q, if_rdata_d;
  logic [31:0]         d_rdata_q, d_rdata_d;

  logic streak_full;
  logic pick_d;
  logic pick_if;

  // Data wins any contest unless fetch has already lost MAX_STREAK in a row.
  assign streak_full = (streak_q == STREAK_W'(MAX_STREAK));
  assign pick_d      = d_req_i && !(if_req_i && streak_full);
  assign pick_if     = if_req_i && !pick_d;

  assign if_gnt_o    = (state_q == IDLE) && pick_if;
  assign d_gnt_o     = (state_q == IDLE) && pick_d;
  assign busy_o      = (state_q != IDLE);
  assign if_valid_o  = (state_q == RESP) && (owner_q == OWN_IF) && !flushed_q;
  assign d_valid_o   = (state_q == RESP) && (owner_q == OWN_D);
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_w_en_o  = mem_w_en_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    wcnt_d      = wcnt_q;
    flushed_d   = flushed_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_w_en_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;

    if (state_q != IDLE && owner_q == OWN_IF && if_flush_i) begin
      flushed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pick_d) begin
          owner_d     = OWN_D;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          mem_w_en_d  = d_we_i;
          flushed_d   = 1'b0;
          if (!if_req_i) begin
            streak_d = '0;
          end else if (!streak_full) begin
            streak_d = streak_q + 1'b1;
          end
          state_d = ACCESS;
        end else if (pick_if) begin
          owner_d    = OWN_IF;
          mem_addr_d = if_addr_i;
          flushed_d  = if_flush_i;
          streak_d   = '0;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        wcnt_d  = WCNT_W'(READ_LAT - 1);
        state_d = mem_w_en_q ? RESP : WAIT;
      end
      WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else if (owner_q == OWN_D) begin
          d_rdata_d = mem_rdata_i;
          state_d   = RESP;
        end else if (flushed_q || if_flush_i) begin
          // A flushed fetch has nothing to deliver, so it skips RESP.
          state_d = IDLE;
        end else begin
          if_rdata_d = mem_rdata_i;
          state_d    = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      wcnt_q      <= '0;
      flushed_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_w_en_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      wcnt_q      <= wcnt_d;
      flushed_q   <= flushed_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_w_en_q  <= mem_w_en_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at READ_LAT=1, one at
// READ_LAT=3, each with its own behavioural RAM of matching latency.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [10:0] if_addr;
  logic        if_flush;
  logic        d_req;
  logic        d_we;
  logic [10:0] d_addr;
  logic [31:0] d_wdata;

  logic        o1_if_gnt, o1_if_valid, o1_d_gnt, o1_d_valid, o1_w_en, o1_busy;
  logic [31:0] o1_if_rdata, o1_d_rdata, o1_wdata, rd1;
  logic [10:0] o1_addr;
  logic        o3_if_gnt, o3_if_valid, o3_d_gnt, o3_d_valid, o3_w_en, o3_busy;
  logic [31:0] o3_if_rdata, o3_d_rdata, o3_wdata, rd3, p3a, p3b;
  logic [10:0] o3_addr;

  logic [31:0] ram1 [0:2047];
  logic [31:0] ram3 [0:2047];

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(11), .READ_LAT(1), .MAX_STREAK(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(o1_if_gnt), .if_valid_o(o1_if_valid), .if_rdata_o(o1_if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(o1_d_gnt), .d_valid_o(o1_d_valid), .d_rdata_o(o1_d_rdata),
    .mem_addr_o(o1_addr), .mem_wdata_o(o1_wdata), .mem_w_en_o(o1_w_en),
    .mem_rdata_i(rd1), .busy_o(o1_busy)
  );

  mem_port_arbiter #(.ADDR_W(11), .READ_LAT(3), .MAX_STREAK(4)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_gnt_o(o3_if_gnt), .if_valid_o(o3_if_valid), .if_rdata_o(o3_if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(o3_d_gnt), .d_valid_o(o3_d_valid), .d_rdata_o(o3_d_rdata),
    .mem_addr_o(o3_addr), .mem_wdata_o(o3_wdata), .mem_w_en_o(o3_w_en),
    .mem_rdata_i(rd3), .busy_o(o3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o1_w_en) ram1[o1_addr] <= o1_wdata;
    rd1 <= ram1[o1_addr];
  end

  always @(posedge clk) begin
    if (o3_w_en) ram3[o3_addr] <= o3_wdata;
    p3a <= ram3[o3_addr];
    p3b <= p3a;
    rd3 <= p3b;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs are driven 2 time units after the edge, outputs sampled 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle1(input string tag);
    for (int i = 0; i < 20 && o1_busy; i++) begin
      next_cycle();
      #1;
    end
    check_eq(tag, 32'(o1_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    logic exp_if;

    for (int i = 0; i < 2048; i++) begin
      ram1[i] = 32'h0;
      ram3[i] = 32'h0;
    end
    ram1[11'h010] = 32'hE3A00001; ram3[11'h010] = 32'hE3A00001;
    ram1[11'h030] = 32'h00003030;
    ram1[11'h040] = 32'h00004040;
    ram1[11'h050] = 32'h12345678;
    ram3[11'h060] = 32'hCAFEF00D;

    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;

    // Reset state
    next_cycle(); next_cycle(); #1;
    $display("txn reset");
    check_eq("rst_busy",     32'(o1_busy), 32'd0);
    check_eq("rst_gnts",     32'({o1_if_gnt, o1_d_gnt}), 32'd0);
    check_eq("rst_valids",   32'({o1_if_valid, o1_d_valid}), 32'd0);
    check_eq("rst_w_en",     32'(o1_w_en), 32'd0);
    check_eq("rst_mem_addr", 32'(o1_addr), 32'd0);
    check_eq("rst_if_rdata", o1_if_rdata, 32'd0);
    next_cycle(); rst_n = 1'b1;

    // Fetch, READ_LAT=1
    next_cycle(); if_req = 1'b1; if_addr = 11'h010; #1;
    $display("txn fetch addr=0x010");
    check_eq("f_if_gnt", 32'(o1_if_gnt), 32'd1);
    check_eq("f_d_gnt",  32'(o1_d_gnt), 32'd0);
    next_cycle(); if_req = 1'b0; #1;
    check_eq("f_mem_addr", 32'(o1_addr), 32'h010);
    check_eq("f_w_en",     32'(o1_w_en), 32'd0);
    check_eq("f_busy",     32'(o1_busy), 32'd1);
    next_cycle(); #1;
    check_eq("f_valid_t2", 32'(o1_if_valid), 32'd0);
    next_cycle(); #1;
    check_eq("f_valid_t3", 32'(o1_if_valid), 32'd1);
    check_eq("f_rdata",    o1_if_rdata, 32'hE3A00001);
    check_eq("f_dvalid",   32'(o1_d_valid), 32'd0);
    next_cycle(); #1;
    check_eq("f_valid_t4", 32'(o1_if_valid), 32'd0);
    check_eq("f_busy_t4",  32'(o1_busy), 32'd0);

    // Store then load-back of the same word
    next_cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 11'h020; d_wdata = 32'hDEADBEEF; #1;
    $display("txn store addr=0x020 data=0xdeadbeef");
    check_eq("s_d_gnt", 32'(o1_d_gnt), 32'd1);
    next_cycle(); d_req = 1'b0; d_we = 1'b0; d_wdata = 32'h0; #1;
    check_eq("s_w_en_t1",  32'(o1_w_en), 32'd1);
    check_eq("s_addr_t1",  32'(o1_addr), 32'h020);
    check_eq("s_wdata_t1", o1_wdata, 32'hDEADBEEF);
    next_cycle(); #1;
    check_eq("s_w_en_t2",  32'(o1_w_en), 32'd0);
    check_eq("s_dvalid",   32'(o1_d_valid), 32'd1);
    check_eq("s_wdata_hold", o1_wdata, 32'hDEADBEEF);
    next_cycle(); #1;
    check_eq("s_dvalid_t3", 32'(o1_d_valid), 32'd0);
    check_eq("s_busy_t3",   32'(o1_busy), 32'd0);
    d_req = 1'b1; d_addr = 11'h020;
    #1;
    $display("txn load addr=0x020");
    check_eq("l_d_gnt", 32'(o1_d_gnt), 32'd1);
    next_cycle(); d_req = 1'b0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    check_eq("l_dvalid", 32'(o1_d_valid), 32'd1);
    check_eq("l_rdata",  o1_d_rdata, 32'hDEADBEEF);
    check_eq("l_if_rdata_hold", o1_if_rdata, 32'hE3A00001);
    wait_idle1("l_idle");

    // Contested: both held, expect D D D D IF repeating
    next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 11'h030; if_req = 1'b1; if_addr = 11'h040; #1;
    ngr = 0;
    for (int c = 0; c < 100 && ngr < 10; c++) begin
      check_eq("gnt_excl", 32'(o1_if_gnt & o1_d_gnt), 32'd0);
      if (o1_if_gnt || o1_d_gnt) begin
        exp_if = (ngr % 5 == 4);
        $display("txn arb grant %0d to %s", ngr, o1_if_gnt ? "IF" : "D");
        check_eq($sformatf("arb_%0d", ngr), 32'(o1_if_gnt), 32'(exp_if));
        ngr++;
      end
      if (ngr < 10) begin
        next_cycle(); #1;
      end
    end
    check_eq("arb_count", 32'(ngr), 32'd10);
    next_cycle(); d_req = 1'b0; if_req = 1'b0;
    #1;
    wait_idle1("arb_idle");
    check_eq("arb_if_rdata", o1_if_rdata, 32'h00004040);

    // Flush in the cycle after grant
    next_cycle(); if_req = 1'b1; if_addr = 11'h050; #1;
    $display("txn fetch addr=0x050 flushed at T+1");
    check_eq("fl_gnt", 32'(o1_if_gnt), 32'd1);
    next_cycle(); if_req = 1'b0; if_flush = 1'b1; #1;
    check_eq("fl_busy_t1", 32'(o1_busy), 32'd1);
    next_cycle(); if_flush = 1'b0; #1;
    check_eq("fl_valid_t2", 32'(o1_if_valid), 32'd0);
    next_cycle(); #1;
    check_eq("fl_busy_t3",  32'(o1_busy), 32'd0);
    check_eq("fl_valid_t3", 32'(o1_if_valid), 32'd0);
    check_eq("fl_rdata",    o1_if_rdata, 32'h00004040);

    // Flush in the grant cycle itself
    next_cycle(); if_req = 1'b1; if_flush = 1'b1; if_addr = 11'h050; #1;
    $display("txn fetch addr=0x050 flushed at grant");
    check_eq("flg_gnt", 32'(o1_if_gnt), 32'd1);
    next_cycle(); if_req = 1'b0; if_flush = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      next_cycle(); #1;
      check_eq("flg_valid", 32'(o1_if_valid), 32'd0);
    end
    check_eq("flg_rdata", o1_if_rdata, 32'h00004040);

    // Asynchronous reset during WAIT of a load
    next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 11'h020; #1;
    $display("txn load addr=0x020 reset in WAIT");
    check_eq("rw_gnt", 32'(o1_d_gnt), 32'd1);
    next_cycle(); d_req = 1'b0; #1;
    next_cycle(); rst_n = 1'b0; #1;
    check_eq("rw_busy",    32'(o1_busy), 32'd0);
    check_eq("rw_dvalid",  32'(o1_d_valid), 32'd0);
    check_eq("rw_d_rdata", o1_d_rdata, 32'd0);
    check_eq("rw_if_rdata", o1_if_rdata, 32'd0);
    check_eq("rw_addr",    32'(o1_addr), 32'd0);
    next_cycle(); #1;
    check_eq("rw_dvalid2", 32'(o1_d_valid), 32'd0);
    next_cycle(); rst_n = 1'b1;

    // Asynchronous reset in ACCESS of a store drops mem_w_en immediately
    next_cycle(); d_req = 1'b1; d_we = 1'b1; d_addr = 11'h070; d_wdata = 32'h55; #1;
    $display("txn store addr=0x070 reset in ACCESS");
    check_eq("ra_gnt", 32'(o1_d_gnt), 32'd1);
    next_cycle(); d_req = 1'b0; d_we = 1'b0; #1;
    check_eq("ra_w_en_pre", 32'(o1_w_en), 32'd1);
    rst_n = 1'b0; #1;
    check_eq("ra_w_en_rst", 32'(o1_w_en), 32'd0);
    next_cycle(); rst_n = 1'b1;

    // Normal grant after reset release
    next_cycle(); if_req = 1'b1; if_addr = 11'h010; #1;
    $display("txn fetch addr=0x010 after reset");
    check_eq("pr_gnt", 32'(o1_if_gnt), 32'd1);
    next_cycle(); if_req = 1'b0; #1;
    next_cycle(); #1;
    next_cycle(); #1;
    check_eq("pr_valid", 32'(o1_if_valid), 32'd1);
    check_eq("pr_rdata", o1_if_rdata, 32'hE3A00001);
    for (int i = 0; i < 6; i++) next_cycle();
    #1;
    check_eq("pr_idle3", 32'(o3_busy), 32'd0);

    // READ_LAT=3 load, fetch held from T+1
    next_cycle(); d_req = 1'b1; d_we = 1'b0; d_addr = 11'h060; #1;
    $display("txn lat3 load addr=0x060");
    check_eq("l3_d_gnt", 32'(o3_d_gnt), 32'd1);
    next_cycle(); d_req = 1'b0; if_req = 1'b1; if_addr = 11'h010; #1;
    check_eq("l3_if_gnt_t1", 32'(o3_if_gnt), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      next_cycle(); #1;
      check_eq($sformatf("l3_dvalid_t%0d", i), 32'(o3_d_valid), 32'd0);
      check_eq($sformatf("l3_if_gnt_t%0d", i), 32'(o3_if_gnt), 32'd0);
    end
    next_cycle(); #1;
    check_eq("l3_dvalid_t5", 32'(o3_d_valid), 32'd1);
    check_eq("l3_rdata",     o3_d_rdata, 32'hCAFEF00D);
    check_eq("l3_if_gnt_t5", 32'(o3_if_gnt), 32'd0);
    next_cycle(); #1;
    check_eq("l3_if_gnt_t6", 32'(o3_if_gnt), 32'd1);
    check_eq("l3_dvalid_t6", 32'(o3_d_valid), 32'd0);
    next_cycle(); if_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
